// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline.
// Holds the NOP encoding, the fetch FSM state type and the default reset PC.
package mips_pkg;

    localparam logic [31:0] NOP          = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_flopenrc.sv
// Width-parameterised flop with synchronous reset, clear and enable.
// Ports: clk, reset, en (load), clr (zero), d, q. Priority: reset > clr > en.
module flopenrc #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, instruction-memory handshake FSM and the
// Fetch/Decode register. Hazard inputs StallF/StallD; redirect inputs
// PCSrcD/JumpD with targets; memory port ImemReq/ImemAddr/ImemRdata/ImemValid;
// outputs PCF, InstrD, PCPlus4D and ImemBusyF (memory wait stall).
// Build option: DELAY_SLOT_EN keeps the instruction fetched alongside a
// redirect (branch delay slot) instead of flushing/draining it.
module fetch_stage
    import mips_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             PCSrcD,
    input  logic             JumpD,
    input  logic [WIDTH-1:0] PCBranchD,
    input  logic [WIDTH-1:0] PCJumpD,
    output logic             ImemReq,
    output logic [WIDTH-1:0] ImemAddr,
    input  logic [WIDTH-1:0] ImemRdata,
    input  logic             ImemValid,
    output logic             ImemBusyF,
    output logic [WIDTH-1:0] PCF,
    output logic [WIDTH-1:0] InstrD,
    output logic [WIDTH-1:0] PCPlus4D
);

    fetch_state_t     state;
    fetch_state_t     state_n;
    fetch_state_t     kill_st;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] pc_next;
    logic             redirect;
    logic             delivered;
    logic             take;
    logic             flush;
    logic [2*WIDTH-1:0] fd_d;
    logic [2*WIDTH-1:0] fd_q;

    assign pc_plus4  = PCF + WIDTH'(4);
    assign redirect  = (JumpD | PCSrcD) & ~StallF;
    // A response in S_DRAIN belongs to a killed fetch.
    assign delivered = ImemValid & (state != S_DRAIN);
    // Under StallF the delivery is dropped and re-requested later.
    assign take      = delivered & ~StallF;

`ifdef DELAY_SLOT_EN
    assign flush   = 1'b0;
    assign kill_st = S_FETCH;
`else
    assign flush   = redirect & ~StallD;
    assign kill_st = S_DRAIN;
`endif

    always_comb begin
        pc_next = PCF;
        priority case (1'b1)
            redirect & JumpD: pc_next = PCJumpD;
            redirect:         pc_next = PCBranchD;
            take:             pc_next = pc_plus4;
            default:          pc_next = PCF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            PCF <= RESET_PC;
        end else begin
            PCF <= pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_n;
        end
    end

    // A request left outstanding across a redirect is wrong-path,
    // whether it was issued this cycle or earlier.
    always_comb begin
        state_n = state;
        unique case (state)
            S_FETCH: begin
                if (!ImemValid) begin
                    state_n = (redirect && kill_st == S_DRAIN) ?
                              S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (ImemValid) begin
                    state_n = S_FETCH;
                end else if (redirect) begin
                    state_n = kill_st;
                end
            end
            S_DRAIN: begin
                if (ImemValid) begin
                    state_n = S_FETCH;
                end
            end
            default: state_n = S_FETCH;
        endcase
    end

    always_comb begin
        ImemReq   = 1'b1;
        ImemAddr  = PCF;
        ImemBusyF = 1'b0;
        unique case (state)
            S_FETCH: begin
                ImemReq   = 1'b1;
                ImemBusyF = 1'b0;
            end
            S_WAIT: begin
                ImemReq   = 1'b1;
                ImemBusyF = 1'b1;
            end
            S_DRAIN: begin
                ImemReq   = 1'b0;
                ImemBusyF = 1'b1;
            end
            default: begin
                ImemReq   = 1'b1;
                ImemBusyF = 1'b0;
            end
        endcase
    end

    assign fd_d = take ? {ImemRdata, pc_plus4}
                       : {WIDTH'(NOP), {WIDTH{1'b0}}};

    flopenrc #(
        .W(2 * WIDTH)
    ) u_fd (
        .clk  (clk),
        .reset(reset),
        .en   (~StallD),
        .clr  (flush),
        .d    (fd_d),
        .q    (fd_q)
    );

    assign InstrD   = fd_q[2*WIDTH-1:WIDTH];
    assign PCPlus4D = fd_q[WIDTH-1:0];

endmodule
